// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory port between the I-cache and the D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build gives the D-cache fixed priority.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int HOLD      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ic_addr,
  input  logic        i_ic_ren,
  output logic        o_ic_ready,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_valid,
  input  logic [31:0] i_dc_addr,
  input  logic        i_dc_ren,
  input  logic        i_dc_wen,
  input  logic [31:0] i_dc_wdata,
  output logic        o_dc_ready,
  output logic [31:0] o_dc_rdata,
  output logic        o_dc_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

  localparam logic [3:0] HOLD_CNT  = 4'(HOLD);
  localparam logic [3:0] BURST_CNT = 4'(MAX_BURST);

  state_t     state;
  logic       pend;
  logic [3:0] idle_cnt;
  logic [3:0] burst_cnt;

  logic       own_i, own_d;
  logic       owner_ren, owner_wen, owner_req, owner_ready;
  logic       resp;
  logic       pend_nxt;
  logic [3:0] idle_nxt, burst_nxt;
  logic       rel_now;
  logic       ic_req, dc_req, grant_d;

  assign ic_req = i_ic_ren;
  assign dc_req = i_dc_ren || i_dc_wen;

`ifdef MEM_ARB_RR_EN
  logic last_d;
  // On a tie the cache that did not own the port most recently wins.
  assign grant_d = dc_req && (!ic_req || !last_d);
`else
  assign grant_d = dc_req;
`endif

  // Release is judged on the post-edge bookkeeping so that a forced release lands the cycle after the last completion.
  always_comb begin
    own_i       = (state == OWN_I);
    own_d       = (state == OWN_D);
    owner_ren   = (own_i && i_ic_ren) || (own_d && i_dc_ren);
    owner_wen   = own_d && i_dc_wen;
    owner_req   = owner_ren || owner_wen;
    owner_ready = i_mem_ready && !pend && owner_req;
    resp        = (own_i || own_d) && i_mem_valid && pend;

    pend_nxt = pend;
    if (owner_ready && owner_ren)
      pend_nxt = 1'b1;
    else if (resp)
      pend_nxt = 1'b0;

    burst_nxt = burst_cnt + {3'b000, owner_ready};

    if (owner_req)
      idle_nxt = 4'd0;
    else if (!pend)
      idle_nxt = idle_cnt + 4'd1;
    else
      idle_nxt = idle_cnt;

    rel_now = !pend_nxt && ((idle_nxt >= HOLD_CNT) || (burst_nxt >= BURST_CNT));
  end

  assign o_mem_addr  = own_i ? i_ic_addr : (own_d ? i_dc_addr : 32'd0);
  assign o_mem_wdata = own_d ? i_dc_wdata : 32'd0;
  assign o_mem_ren   = owner_ren && !pend;
  assign o_mem_wen   = owner_wen && !pend;

  assign o_ic_ready  = own_i && owner_ready;
  assign o_dc_ready  = own_d && owner_ready;
  assign o_ic_valid  = own_i && resp;
  assign o_dc_valid  = own_d && resp;
  assign o_ic_rdata  = o_ic_valid ? i_mem_rdata : 32'd0;
  assign o_dc_rdata  = o_dc_valid ? i_mem_rdata : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      pend      <= 1'b0;
      idle_cnt  <= 4'd0;
      burst_cnt <= 4'd0;
`ifdef MEM_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          idle_cnt  <= 4'd0;
          burst_cnt <= 4'd0;
          if (ic_req || dc_req)
            state <= grant_d ? OWN_D : OWN_I;
        end
        OWN_I, OWN_D: begin
          pend      <= pend_nxt;
          idle_cnt  <= idle_nxt;
          burst_cnt <= burst_nxt;
          if (rel_now) begin
            state <= IDLE;
`ifdef MEM_ARB_RR_EN
            last_d <= own_d;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and randomized traffic
// scored against a transaction-level model of two well-behaved caches and a memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int HOLD      = 2;
  localparam int MAX_BURST = 4;
  localparam int NV        = 12;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ic_addr, i_dc_addr, i_dc_wdata, i_mem_rdata;
  logic        i_ic_ren, i_dc_ren, i_dc_wen, i_mem_ready, i_mem_valid;
  logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid, o_mem_ren, o_mem_wen;
  logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_addr, o_mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.HOLD(HOLD), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ic_addr(i_ic_addr), .i_ic_ren(i_ic_ren), .o_ic_ready(o_ic_ready),
    .o_ic_rdata(o_ic_rdata), .o_ic_valid(o_ic_valid),
    .i_dc_addr(i_dc_addr), .i_dc_ren(i_dc_ren), .i_dc_wen(i_dc_wen), .i_dc_wdata(i_dc_wdata),
    .o_dc_ready(o_dc_ready), .o_dc_rdata(o_dc_rdata), .o_dc_valid(o_dc_valid),
    .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        ic_ren;
    logic [31:0] ic_addr;
    logic        dc_ren, dc_wen;
    logic [31:0] dc_addr, dc_wdata;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;
    logic        e_ic_ready, e_dc_ready, e_ic_valid, e_dc_valid, e_ren, e_wen;
    logic [31:0] e_addr, e_wdata, e_ic_rdata;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t row(
    input logic icr, input logic [31:0] ica,
    input logic dcr, input logic dcw, input logic [31:0] dca, input logic [31:0] dcd,
    input logic mr, input logic mv, input logic [31:0] md,
    input logic eicr, input logic edcr, input logic eicv, input logic edcv,
    input logic eren, input logic ewen,
    input logic [31:0] eaddr, input logic [31:0] ewd, input logic [31:0] erd);
    vec_t v;
    v.ic_ren = icr; v.ic_addr = ica;
    v.dc_ren = dcr; v.dc_wen = dcw; v.dc_addr = dca; v.dc_wdata = dcd;
    v.mem_ready = mr; v.mem_valid = mv; v.mem_rdata = md;
    v.e_ic_ready = eicr; v.e_dc_ready = edcr; v.e_ic_valid = eicv; v.e_dc_valid = edcv;
    v.e_ren = eren; v.e_wen = ewen; v.e_addr = eaddr; v.e_wdata = ewd; v.e_ic_rdata = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_ic_addr = 32'd0; i_ic_ren = 1'b0;
    i_dc_addr = 32'd0; i_dc_ren = 1'b0; i_dc_wen = 1'b0; i_dc_wdata = 32'd0;
    i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, " mem_addr"},  o_mem_addr,  32'd0);
    checkOutput({tag, " mem_wdata"}, o_mem_wdata, 32'd0);
    checkBit({tag, " mem_ren"},  o_mem_ren,  1'b0);
    checkBit({tag, " mem_wen"},  o_mem_wen,  1'b0);
    checkBit({tag, " ic_ready"}, o_ic_ready, 1'b0);
    checkBit({tag, " dc_ready"}, o_dc_ready, 1'b0);
    checkBit({tag, " ic_valid"}, o_ic_valid, 1'b0);
    checkBit({tag, " dc_valid"}, o_dc_valid, 1'b0);
    checkOutput({tag, " ic_rdata"}, o_ic_rdata, 32'd0);
    checkOutput({tag, " dc_rdata"}, o_dc_rdata, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    i_ic_ren = v.ic_ren; i_ic_addr = v.ic_addr;
    i_dc_ren = v.dc_ren; i_dc_wen = v.dc_wen; i_dc_addr = v.dc_addr; i_dc_wdata = v.dc_wdata;
    i_mem_ready = v.mem_ready; i_mem_valid = v.mem_valid; i_mem_rdata = v.mem_rdata;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkBit($sformatf("vec%0d ic_ready", idx), o_ic_ready, v.e_ic_ready);
    checkBit($sformatf("vec%0d dc_ready", idx), o_dc_ready, v.e_dc_ready);
    checkBit($sformatf("vec%0d ic_valid", idx), o_ic_valid, v.e_ic_valid);
    checkBit($sformatf("vec%0d dc_valid", idx), o_dc_valid, v.e_dc_valid);
    checkBit($sformatf("vec%0d mem_ren", idx), o_mem_ren, v.e_ren);
    checkBit($sformatf("vec%0d mem_wen", idx), o_mem_wen, v.e_wen);
    checkOutput($sformatf("vec%0d mem_addr", idx), o_mem_addr, v.e_addr);
    checkOutput($sformatf("vec%0d mem_wdata", idx), o_mem_wdata, v.e_wdata);
    checkOutput($sformatf("vec%0d ic_rdata", idx), o_ic_rdata, v.e_ic_rdata);
    checkOutput($sformatf("vec%0d dc_rdata", idx), o_dc_rdata, 32'd0);
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          exp_d[3];
    int          ic_st, dc_st, mem_cd, drain_cycles;
    bit          dc_is_wr, mem_pend, mem_owner_d, resp_now, drain, acc;
    logic [31:0] ic_req_addr, dc_req_addr, pend_req_addr;

    // Single read, HOLD release, a write, a stray response and a regrant to the other cache.
    //              icr  ica      dcr dcw dca     dcd      mr mv md            eicr edcr eicv edcv ren wen addr    wdata    ic_rdata
    vecs[0]  = row(1, 32'h100, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,    32'h0);
    vecs[1]  = row(1, 32'h100, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        1, 0, 0, 0, 1, 0, 32'h100, 32'h0,    32'h0);
    vecs[2]  = row(0, 32'h100, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h100, 32'h0,    32'h0);
    vecs[3]  = row(0, 32'h100, 0, 0, 32'h0,  32'h0,    1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 32'h100, 32'h0,    32'hDEADBEEF);
    vecs[4]  = row(0, 32'h100, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h100, 32'h0,    32'h0);
    vecs[5]  = row(0, 32'h100, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h100, 32'h0,    32'h0);
    vecs[6]  = row(0, 32'h100, 0, 1, 32'h40, 32'h55AA, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,    32'h0);
    vecs[7]  = row(0, 32'h100, 0, 1, 32'h40, 32'h55AA, 1, 0, 32'h0,        0, 1, 0, 0, 0, 1, 32'h40,  32'h55AA, 32'h0);
    vecs[8]  = row(1, 32'h104, 0, 0, 32'h40, 32'h55AA, 1, 1, 32'h12345678, 0, 0, 0, 0, 0, 0, 32'h40,  32'h55AA, 32'h0);
    vecs[9]  = row(1, 32'h104, 0, 0, 32'h40, 32'h55AA, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h40,  32'h55AA, 32'h0);
    vecs[10] = row(1, 32'h104, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,   32'h0,    32'h0);
    vecs[11] = row(1, 32'h104, 0, 0, 32'h0,  32'h0,    1, 0, 32'h0,        1, 0, 0, 0, 1, 0, 32'h104, 32'h0,    32'h0);

    i_rst_n = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      next_cycle();
      applyStimulus(vecs[i]);
      settle();
      checkVector(i, vecs[i]);
    end

    // Reset while the read from vector 11 is still outstanding, then a late response.
    next_cycle();
    i_ic_ren = 1'b0;
    settle();
    checkOutput("pre-reset mem_addr", o_mem_addr, 32'h104);
    i_mem_valid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midop reset");
    next_cycle();
    i_rst_n = 1'b1;
    settle();
    checkBit("late resp ic_valid", o_ic_valid, 1'b0);
    checkBit("late resp dc_valid", o_dc_valid, 1'b0);
    checkOutput("late resp ic_rdata", o_ic_rdata, 32'd0);

    // Line fill: four reads under one grant, forced release with a fifth held.
    do_reset();
    i_ic_ren = 1'b1; i_ic_addr = 32'h200; i_mem_ready = 1'b1;
    settle();
    checkBit("fill arb ic_ready", o_ic_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      i_ic_ren = 1'b1; i_ic_addr = 32'h200 + 32'(4 * k); i_mem_valid = 1'b0;
      settle();
      checkBit($sformatf("fill%0d ic_ready", k), o_ic_ready, 1'b1);
      checkOutput($sformatf("fill%0d mem_addr", k), o_mem_addr, 32'h200 + 32'(4 * k));
      next_cycle();
      i_ic_ren = 1'b0;
      settle();
      checkBit($sformatf("fill%0d wait ic_valid", k), o_ic_valid, 1'b0);
      next_cycle();
      i_mem_valid = 1'b1; i_mem_rdata = 32'hF00D_0000 + 32'(k);
      settle();
      checkBit($sformatf("fill%0d ic_valid", k), o_ic_valid, 1'b1);
      checkOutput($sformatf("fill%0d ic_rdata", k), o_ic_rdata, 32'hF00D_0000 + 32'(k));
    end
    next_cycle();
    i_mem_valid = 1'b0; i_ic_ren = 1'b1; i_ic_addr = 32'h210;
    settle();
    checkBit("fill5 released ic_ready", o_ic_ready, 1'b0);
    checkBit("fill5 released mem_ren", o_mem_ren, 1'b0);
    next_cycle();
    settle();
    checkBit("fill5 regrant ic_ready", o_ic_ready, 1'b1);
    checkOutput("fill5 regrant mem_addr", o_mem_addr, 32'h210);

    // Three simultaneous-request arbitrations.
`ifdef MEM_ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
    do_reset();
    i_ic_addr = 32'h300; i_dc_addr = 32'h400; i_mem_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      i_ic_ren = 1'b1; i_dc_ren = 1'b1; i_mem_valid = 1'b0;
      settle();
      checkBit($sformatf("arb%0d idle ic_ready", r), o_ic_ready, 1'b0);
      checkBit($sformatf("arb%0d idle dc_ready", r), o_dc_ready, 1'b0);
      next_cycle();
      settle();
      checkBit($sformatf("arb%0d ic_ready", r), o_ic_ready, !exp_d[r]);
      checkBit($sformatf("arb%0d dc_ready", r), o_dc_ready, exp_d[r]);
      next_cycle();
      if (exp_d[r]) i_dc_ren = 1'b0; else i_ic_ren = 1'b0;
      settle();
      next_cycle();
      i_mem_valid = 1'b1; i_mem_rdata = 32'hAB00 + 32'(r);
      settle();
      checkBit($sformatf("arb%0d ic_valid", r), o_ic_valid, !exp_d[r]);
      checkBit($sformatf("arb%0d dc_valid", r), o_dc_valid, exp_d[r]);
      next_cycle();
      i_mem_valid = 1'b0;
      settle();
      checkBit($sformatf("arb%0d hold ic_ready", r), o_ic_ready, 1'b0);
      next_cycle();
      settle();
      next_cycle();
    end

    // Write-through with the memory stalling for three cycles while the I-cache waits.
    do_reset();
    i_dc_wen = 1'b1; i_dc_addr = 32'h40; i_dc_wdata = 32'h55AA;
    settle();
    checkBit("wt arb dc_ready", o_dc_ready, 1'b0);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      i_ic_ren = 1'b1; i_ic_addr = 32'h500;
      settle();
      checkBit($sformatf("wt stall%0d dc_ready", s), o_dc_ready, 1'b0);
      checkBit($sformatf("wt stall%0d mem_wen", s), o_mem_wen, 1'b1);
      checkOutput($sformatf("wt stall%0d mem_addr", s), o_mem_addr, 32'h40);
      checkBit($sformatf("wt stall%0d ic_ready", s), o_ic_ready, 1'b0);
    end
    next_cycle();
    i_mem_ready = 1'b1;
    settle();
    checkBit("wt accept dc_ready", o_dc_ready, 1'b1);
    checkOutput("wt accept wdata", o_mem_wdata, 32'h55AA);
    checkBit("wt accept dc_valid", o_dc_valid, 1'b0);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      i_dc_wen = 1'b0;
      settle();
      checkBit($sformatf("wt after%0d dc_valid", s), o_dc_valid, 1'b0);
      checkBit($sformatf("wt after%0d ic_ready", s), o_ic_ready, 1'b0);
    end
    next_cycle();
    settle();
    checkBit("wt icache granted", o_ic_ready, 1'b1);

    // Randomized traffic from two well-behaved caches against a simple memory.
    do_reset();
    ic_st = 0; dc_st = 0; mem_pend = 0; mem_cd = 0; mem_owner_d = 0; dc_is_wr = 0;
    ic_req_addr = 0; dc_req_addr = 0; pend_req_addr = 0;
    drain = 0; drain_cycles = 0;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      if (cyc == 3000) drain = 1;
      if (drain && ic_st == 0 && dc_st == 0) break;
      if (drain) drain_cycles++;
      next_cycle();
      if (!drain && ic_st == 0 && $urandom_range(0, 9) < 3) begin
        ic_st = 1; ic_req_addr = $urandom & 32'h0000_FFFC;
      end
      if (!drain && dc_st == 0 && $urandom_range(0, 9) < 2) begin
        dc_st = 1; dc_req_addr = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
        dc_is_wr = 1'($urandom_range(0, 1)); i_dc_wdata = $urandom;
      end
      i_ic_addr = ic_req_addr; i_dc_addr = dc_req_addr;
      i_ic_ren = (ic_st == 1);
      i_dc_ren = (dc_st == 1) && !dc_is_wr;
      i_dc_wen = (dc_st == 1) && dc_is_wr;
      i_mem_ready = ($urandom_range(0, 3) != 0);
      resp_now = 0; i_mem_valid = 1'b0; i_mem_rdata = 32'd0;
      if (mem_pend) begin
        mem_cd--;
        if (mem_cd == 0) begin
          resp_now = 1; i_mem_valid = 1'b1; i_mem_rdata = data_of(pend_req_addr);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        i_mem_valid = 1'b1; i_mem_rdata = $urandom;
      end
      settle();

      checkBit("rnd ic_valid", o_ic_valid, resp_now && !mem_owner_d);
      checkBit("rnd dc_valid", o_dc_valid, resp_now && mem_owner_d);
      checkOutput("rnd ic_rdata", o_ic_rdata, (resp_now && !mem_owner_d) ? data_of(ic_req_addr) : 32'd0);
      checkOutput("rnd dc_rdata", o_dc_rdata, (resp_now && mem_owner_d) ? data_of(dc_req_addr) : 32'd0);
      acc = i_mem_ready && (o_mem_ren || o_mem_wen);
      checkOutput("rnd ready count", 32'(o_ic_ready) + 32'(o_dc_ready), 32'(acc));
      if (o_ic_ready) begin
        checkOutput("rnd ic req pending", 32'(ic_st), 32'd1);
        checkOutput("rnd ic mem_addr", o_mem_addr, ic_req_addr);
        checkBit("rnd ic mem_ren", o_mem_ren, 1'b1);
        checkBit("rnd ic one outstanding", mem_pend, 1'b0);
      end
      if (o_dc_ready) begin
        checkOutput("rnd dc req pending", 32'(dc_st), 32'd1);
        checkOutput("rnd dc mem_addr", o_mem_addr, dc_req_addr);
        checkBit("rnd dc mem_wen", o_mem_wen, dc_is_wr);
        checkBit("rnd dc mem_ren", o_mem_ren, !dc_is_wr);
        checkBit("rnd dc one outstanding", mem_pend, 1'b0);
        if (dc_is_wr) checkOutput("rnd dc wdata", o_mem_wdata, i_dc_wdata);
      end

      if (resp_now) begin
        mem_pend = 0;
        if (mem_owner_d) dc_st = 0; else ic_st = 0;
      end
      if (o_ic_ready) begin
        ic_st = 2; mem_pend = 1; mem_owner_d = 0; pend_req_addr = o_mem_addr;
        mem_cd = $urandom_range(1, 3);
      end
      if (o_dc_ready) begin
        if (dc_is_wr) dc_st = 0;
        else begin
          dc_st = 2; mem_pend = 1; mem_owner_d = 1; pend_req_addr = o_mem_addr;
          mem_cd = $urandom_range(1, 3);
        end
      end
    end
    checkOutput("drain ic idle", 32'(ic_st), 32'd0);
    checkOutput("drain dc idle", 32'(dc_st), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
